// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encodings and flag bit positions for the ALU sequencer
package alu_pkg;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam int FLAG_W    = 4;
  localparam int FLAG_NEG  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 0;

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - rising-edge detector producing a one-cycle pulse
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  // Previous-cycle sample; resets high so a level held through reset is not a press
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/alu_io_sequencer.sv
// rtl/alu_io_sequencer.sv - button-driven operand/operation loader and result capture for an external ALU
module alu_io_sequencer
  import alu_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_data,
  input  logic [3:0]   sw_sel,
  input  logic         sw_flag,
  input  logic         btn_next,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  output logic         alu_flagin,
  input  logic [N-1:0] alu_resultado,
  input  logic         alu_negativo,
  input  logic         alu_zero,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic [2:0]   state_o,
  output logic         done
);

  state_t state, state_nx;
  logic   btn_pe;
  logic   ld_a, ld_b, ld_op, capture, clr_done;
  logic [FLAG_W-1:0] flags_in;

  detector_flanco u_det (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_next),
    .pulse (btn_pe)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD_A;
    else     state <= state_nx;
  end

  // Next state: load states advance on a press, EXEC always advances, unknown codes recover
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD_A:  if (btn_pe) state_nx = S_LOAD_B;
      S_LOAD_B:  if (btn_pe) state_nx = S_LOAD_OP;
      S_LOAD_OP: if (btn_pe) state_nx = S_EXEC;
      S_EXEC:    state_nx = S_SHOW;
      S_SHOW:    if (btn_pe) state_nx = S_LOAD_A;
      default:   state_nx = S_LOAD_A;
    endcase
  end

  // Per-state register enables
  always_comb begin
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    capture  = 1'b0;
    clr_done = 1'b0;
    case (state)
      S_LOAD_A:  ld_a     = btn_pe;
      S_LOAD_B:  ld_b     = btn_pe;
      S_LOAD_OP: ld_op    = btn_pe;
      S_EXEC:    capture  = 1'b1;
      S_SHOW:    clr_done = btn_pe;
      default:   ;
    endcase
  end

  // Pack the ALU flags into their shared bit positions
  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_NEG]  = alu_negativo;
    flags_in[FLAG_ZERO] = alu_zero;
    flags_in[FLAG_COUT] = alu_cout;
    flags_in[FLAG_OVF]  = alu_overflow;
  end

  // Operand, operation and result registers; each only changes in its own step
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      alu_flagin <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      done       <= 1'b0;
    end else begin
      if (ld_a) alu_a <= sw_data;
      if (ld_b) alu_b <= sw_data;
      if (ld_op) begin
        alu_select <= sw_sel;
        alu_flagin <= sw_flag;
      end
      if (capture) begin
        res_q   <= alu_resultado;
        flags_q <= flags_in;
        done    <= 1'b1;
      end else if (clr_done) begin
        done <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_io_sequencer.sv
// tb/tb_alu_io_sequencer.sv - self-checking bench for alu_io_sequencer with a behavioural ALU
module tb_alu_io_sequencer;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw_data;
  logic [3:0]   sw_sel;
  logic         sw_flag;
  logic         btn_next;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_select;
  logic         alu_flagin;
  logic [N-1:0] m_res;
  logic         m_neg, m_zero, m_cout, m_ovf;
  logic [N:0]   sum;
  logic [N-1:0] res_q;
  logic [3:0]   flags_q;
  logic [2:0]   state_o;
  logic         done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_io_sequencer #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_data       (sw_data),
    .sw_sel        (sw_sel),
    .sw_flag       (sw_flag),
    .btn_next      (btn_next),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_select    (alu_select),
    .alu_flagin    (alu_flagin),
    .alu_resultado (m_res),
    .alu_negativo  (m_neg),
    .alu_zero      (m_zero),
    .alu_cout      (m_cout),
    .alu_overflow  (m_ovf),
    .res_q         (res_q),
    .flags_q       (flags_q),
    .state_o       (state_o),
    .done          (done)
  );

  // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, others xor with flagin/select-driven flags
  always_comb begin
    sum    = {1'b0, alu_a} + {1'b0, alu_b};
    m_res  = '0;
    m_neg  = 1'b0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    case (alu_select)
      4'd0: begin m_res = sum[N-1:0]; m_cout = sum[N]; end
      4'd1: begin m_res = alu_a - alu_b; m_neg = (alu_a < alu_b); m_cout = (alu_a < alu_b); end
      4'd2: m_res = alu_a & alu_b;
      4'd3: m_res = alu_a | alu_b;
      default: begin
        m_res  = alu_a ^ alu_b;
        m_neg  = m_res[N-1];
        m_cout = alu_flagin;
        m_ovf  = alu_select[0];
      end
    endcase
    m_zero = (m_res == '0);
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   sel;
    logic         flag;
    logic [N-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [N-1:0] d);
    sw_data  = d;
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_row(input vec_t v);
    press(v.a);
    check("load_a state", int'(state_o), 1);
    press(v.b);
    check("load_b state", int'(state_o), 2);
    sw_sel   = v.sel;
    sw_flag  = v.flag;
    btn_next = 1'b1;
    @(negedge clk);
    check("exec state", int'(state_o), 3);
    check("exec done low", int'(done), 0);
    btn_next = 1'b0;
    @(negedge clk);
    check("show state", int'(state_o), 4);
    check("res_q", int'(res_q), int'(v.res));
    check("flags_q", int'(flags_q), int'(v.flags));
    check("done set", int'(done), 1);
    check("alu_a", int'(alu_a), int'(v.a));
    check("alu_b", int'(alu_b), int'(v.b));
    check("alu_select", int'(alu_select), int'(v.sel));
    check("alu_flagin", int'(alu_flagin), int'(v.flag));
    sw_data = ~v.a;
    sw_sel  = ~v.sel;
    sw_flag = ~v.flag;
    repeat (3) @(negedge clk);
    check("show hold res", int'(res_q), int'(v.res));
    check("show hold flags", int'(flags_q), int'(v.flags));
    check("show hold done", int'(done), 1);
    check("show hold state", int'(state_o), 4);
    press(~v.a);
    check("back to load_a", int'(state_o), 0);
    check("done cleared", int'(done), 0);
    check("a kept", int'(alu_a), int'(v.a));
    check("sel kept", int'(alu_select), int'(v.sel));
  endtask

  initial begin
    tbl[0] = '{a:3'd3, b:3'd2, sel:4'd0,  flag:1'b0, res:3'd5, flags:4'b0000};
    tbl[1] = '{a:3'd7, b:3'd1, sel:4'd0,  flag:1'b0, res:3'd0, flags:4'b0110};
    tbl[2] = '{a:3'd2, b:3'd5, sel:4'd1,  flag:1'b0, res:3'd5, flags:4'b1010};
    tbl[3] = '{a:3'd6, b:3'd3, sel:4'd2,  flag:1'b0, res:3'd2, flags:4'b0000};
    tbl[4] = '{a:3'd4, b:3'd0, sel:4'd2,  flag:1'b1, res:3'd0, flags:4'b0100};
    tbl[5] = '{a:3'd5, b:3'd2, sel:4'd15, flag:1'b1, res:3'd7, flags:4'b1011};
    tbl[6] = '{a:3'd3, b:3'd3, sel:4'd10, flag:1'b0, res:3'd0, flags:4'b0100};
    tbl[7] = '{a:3'd1, b:3'd6, sel:4'd3,  flag:1'b1, res:3'd7, flags:4'b0000};

    rst      = 1'b1;
    btn_next = 1'b0;
    sw_data  = '0;
    sw_sel   = '0;
    sw_flag  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset state", int'(state_o), 0);
    check("reset alu_a", int'(alu_a), 0);
    check("reset res_q", int'(res_q), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_row(tbl[i]);

    // Held button advances once
    sw_data  = 3'd5;
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    check("held state", int'(state_o), 1);
    check("held alu_a", int'(alu_a), 5);
    btn_next = 1'b0;
    @(negedge clk);
    check("held released state", int'(state_o), 1);

    // Reset in S_LOAD_OP with a simultaneous press
    press(3'd6);
    check("pre-reset state", int'(state_o), 2);
    check("pre-reset res_q", int'(res_q), 7);
    rst      = 1'b1;
    btn_next = 1'b1;
    sw_sel   = 4'd9;
    sw_flag  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort state", int'(state_o), 0);
    check("abort alu_a", int'(alu_a), 0);
    check("abort alu_b", int'(alu_b), 0);
    check("abort alu_select", int'(alu_select), 0);
    check("abort alu_flagin", int'(alu_flagin), 0);
    check("abort res_q", int'(res_q), 0);
    check("abort flags_q", int'(flags_q), 0);
    check("abort done", int'(done), 0);

    // Button still high through reset release must not count
    repeat (3) @(negedge clk);
    check("held through reset state", int'(state_o), 0);
    check("held through reset alu_a", int'(alu_a), 0);
    btn_next = 1'b0;
    @(negedge clk);
    check("after release state", int'(state_o), 0);
    press(3'd3);
    check("repress state", int'(state_o), 1);
    check("repress alu_a", int'(alu_a), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
